// File: rtl/decoder_scan_pkg.sv
// Shared types and sizing for the decoder scan sequencer.
package decoder_scan_pkg;
   typedef enum logic [1:0] {IDLE, DWELL, BLANK} scan_state_t;
   localparam int SLOT_COUNT = 8;
   localparam int SLOT_W     = 3;
endpackage

// File: rtl/decoder_scan_next_slot.sv
// Picks the lowest enabled slot above the current one, falling back to the lowest enabled slot on wrap.
module decoder_scan_next_slot
   import decoder_scan_pkg::*;
(
   input  logic [SLOT_COUNT-1:0] mask,
   input  logic [SLOT_W-1:0]     slot,
   output logic [SLOT_W-1:0]     next_slot,
   output logic                  wrap,
   output logic                  none_set
);
   always_comb begin
      next_slot = '0;
      wrap      = 1'b1;
      none_set  = (mask == '0);
      // Descending scan so the last hit is the lowest qualifying bit.
      for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
         if (mask[i] && (i > int'(slot))) begin
            next_slot = SLOT_W'(i);
            wrap      = 1'b0;
         end
      end
      if (wrap) begin
         for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
            if (mask[i]) next_slot = SLOT_W'(i);
         end
      end
   end
endmodule

// File: rtl/decoder_scan_sequencer.sv
// Drives a 3:8 decoder through the masked slots with a dwell (enabled) and blank (disabled) phase per slot.
// Define SCAN_SEQ_HOLD_EN to add Hold_In, which freezes an active scan in place.
module decoder_scan_sequencer
   import decoder_scan_pkg::*;
#(
   parameter int DWELL_CYCLES = 16,
   parameter int BLANK_CYCLES = 2,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  Clock_In,
   input  logic                  Reset_In,
   input  logic                  Start_In,
   input  logic                  Stop_In,
   input  logic                  Single_Shot_In,
   input  logic [SLOT_COUNT-1:0] Slot_Mask_In,
`ifdef SCAN_SEQ_HOLD_EN
   input  logic                  Hold_In,
`endif
   output logic                  Enable_Out,
   output logic [SLOT_W-1:0]     Encoded_Value_Out,
   output logic                  Slot_Start_Out,
   output logic                  Pass_Done_Out,
   output logic                  Busy_Out
);
   localparam logic [CNT_WIDTH-1:0] DWELL_LAST = CNT_WIDTH'(DWELL_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] BLANK_LAST =
      CNT_WIDTH'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

   scan_state_t          state;
   logic [CNT_WIDTH-1:0] cnt;
   logic [SLOT_W-1:0]    cur_slot, next_slot;
   logic                 wrap, none_set, hold, sel_edge;

   // From IDLE, searching above the top slot always wraps to the lowest enabled slot.
   assign cur_slot = (state == IDLE) ? SLOT_W'(SLOT_COUNT - 1) : Encoded_Value_Out;

   decoder_scan_next_slot u_next (
      .mask      (Slot_Mask_In),
      .slot      (cur_slot),
      .next_slot (next_slot),
      .wrap      (wrap),
      .none_set  (none_set)
   );

`ifdef SCAN_SEQ_HOLD_EN
   assign hold = Hold_In && (state != IDLE);
`else
   assign hold = 1'b0;
`endif

   assign sel_edge = ((state == BLANK) && (cnt == BLANK_LAST)) ||
                     ((state == DWELL) && (cnt == DWELL_LAST) && (BLANK_CYCLES == 0));

   always_ff @(posedge Clock_In) begin
      if (Reset_In || Stop_In) begin
         state             <= IDLE;
         cnt               <= '0;
         Enable_Out        <= 1'b0;
         Encoded_Value_Out <= '0;
         Slot_Start_Out    <= 1'b0;
         Pass_Done_Out     <= 1'b0;
         Busy_Out          <= 1'b0;
      end else if (hold) begin
         Slot_Start_Out <= 1'b0;
         Pass_Done_Out  <= 1'b0;
      end else begin
         Slot_Start_Out <= 1'b0;
         Pass_Done_Out  <= 1'b0;
         if (sel_edge) begin
            cnt           <= '0;
            Pass_Done_Out <= wrap;
            if (none_set || (wrap && Single_Shot_In)) begin
               state      <= IDLE;
               Enable_Out <= 1'b0;
               Busy_Out   <= 1'b0;
            end else begin
               state             <= DWELL;
               Enable_Out        <= 1'b1;
               Slot_Start_Out    <= 1'b1;
               Encoded_Value_Out <= next_slot;
            end
         end else begin
            case (state)
               IDLE: if (Start_In && !none_set) begin
                  state             <= DWELL;
                  cnt               <= '0;
                  Enable_Out        <= 1'b1;
                  Busy_Out          <= 1'b1;
                  Slot_Start_Out    <= 1'b1;
                  Encoded_Value_Out <= next_slot;
               end
               DWELL: if (cnt == DWELL_LAST) begin
                  state      <= BLANK;
                  cnt        <= '0;
                  Enable_Out <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
               BLANK:   cnt <= cnt + 1'b1;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench: two sequencers (blank=2 and blank=0) on shared inputs, checked against a slot-period model.
module tb_decoder_scan_sequencer;
   logic       clk = 1'b0;
   logic       rst, start, stop, single;
   logic [7:0] mask;
`ifdef SCAN_SEQ_HOLD_EN
   logic       hold = 1'b0;
`endif
   logic       en_a, ss_a, pd_a, busy_a, en_b, ss_b, pd_b, busy_b;
   logic [2:0] enc_a, enc_b;
   logic [6:0] act_a, act_b;

   assign act_a = {en_a, enc_a, ss_a, pd_a, busy_a};
   assign act_b = {en_b, enc_b, ss_b, pd_b, busy_b};

   always #5 clk = ~clk;

   decoder_scan_sequencer #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .CNT_WIDTH(8)) dut_a (
      .Clock_In(clk), .Reset_In(rst), .Start_In(start), .Stop_In(stop),
      .Single_Shot_In(single), .Slot_Mask_In(mask),
`ifdef SCAN_SEQ_HOLD_EN
      .Hold_In(hold),
`endif
      .Enable_Out(en_a), .Encoded_Value_Out(enc_a), .Slot_Start_Out(ss_a),
      .Pass_Done_Out(pd_a), .Busy_Out(busy_a));

   decoder_scan_sequencer #(.DWELL_CYCLES(4), .BLANK_CYCLES(0), .CNT_WIDTH(16)) dut_b (
      .Clock_In(clk), .Reset_In(rst), .Start_In(start), .Stop_In(stop),
      .Single_Shot_In(single), .Slot_Mask_In(mask),
`ifdef SCAN_SEQ_HOLD_EN
      .Hold_In(hold),
`endif
      .Enable_Out(en_b), .Encoded_Value_Out(enc_b), .Slot_Start_Out(ss_b),
      .Pass_Done_Out(pd_b), .Busy_Out(busy_b));

   // Model: position inside the slot period; enable is high for the first DWELL positions.
   bit m_busy[2], m_en[2], m_ss[2], m_pd[2];
   int m_slot[2], m_pos[2];
   int vectors = 0, miscompares = 0, cyc = 0;

   function automatic int lowest_above(logic [7:0] m, int s);
      for (int i = s + 1; i < 8; i++) if (m[i]) return i;
      return -1;
   endfunction

   function automatic logic [6:0] expw(int k);
      return {m_en[k], 3'(m_slot[k]), m_ss[k], m_pd[k], m_busy[k]};
   endfunction

   task automatic model_step(int k, int d, int b);
      int nx;
      m_ss[k] = 0;
      m_pd[k] = 0;
      if (rst || stop) begin
         m_busy[k] = 0; m_en[k] = 0; m_slot[k] = 0; m_pos[k] = 0;
      end else if (!m_busy[k]) begin
         if (start && mask != 0) begin
            m_busy[k] = 1; m_en[k] = 1; m_ss[k] = 1; m_pos[k] = 0;
            m_slot[k] = lowest_above(mask, -1);
         end
      end else begin
         m_pos[k]++;
         if (m_pos[k] == d + b) begin
            m_pos[k] = 0;
            nx = lowest_above(mask, m_slot[k]);
            if (nx < 0) begin
               m_pd[k] = 1;
               if (single || mask == 0) begin m_busy[k] = 0; m_en[k] = 0; end
               else nx = lowest_above(mask, -1);
            end
            if (m_busy[k]) begin m_slot[k] = nx; m_en[k] = 1; m_ss[k] = 1; end
         end else begin
            m_en[k] = (m_pos[k] < d);
         end
      end
   endtask

   // Inputs set before the call are sampled at the coming rising edge; returns at the next falling edge.
   task automatic advance();
      model_step(0, 4, 2);
      model_step(1, 4, 0);
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1; start = 0; stop = 0; single = 0; mask = 8'h00;
      advance(); advance();
      vectors++;
      if (act_a !== 7'h00) begin miscompares++; $display("FAIL reset_a: got %b expected %b", act_a, 7'h00); end
      vectors++;
      if (act_b !== 7'h00) begin miscompares++; $display("FAIL reset_b: got %b expected %b", act_b, 7'h00); end
      rst = 0;
   endtask

   task automatic test_continuous();
      int pd_cyc[$];
      int seq[$];
      int en_cnt = 0, t0;
      mask = 8'hFF; single = 0; start = 1;
      advance();
      start = 0; t0 = cyc;
      for (int i = 0; i < 110; i++) begin
         vectors++;
         if ({act_a, act_b} !== {expw(0), expw(1)}) begin
            miscompares++;
            $display("FAIL cont_cycle %0d: got %b/%b expected %b/%b", i, act_a, act_b, expw(0), expw(1));
         end
         if (ss_a) seq.push_back(int'(enc_a));
         if (pd_a) pd_cyc.push_back(cyc);
         if (en_a && cyc < t0 + 48) en_cnt++;
         advance();
      end
      vectors++;
      if (en_cnt !== 32) begin miscompares++; $display("FAIL cont_enable_count: got %0d expected 32", en_cnt); end
      vectors++;
      if (pd_cyc.size() < 2 || pd_cyc[0] != t0 + 48 || pd_cyc[1] - pd_cyc[0] != 48) begin
         miscompares++;
         $display("FAIL cont_pass_done: got %0d pulses, first at +%0d expected first at +48 then every 48",
                  pd_cyc.size(), (pd_cyc.size() > 0) ? pd_cyc[0] - t0 : -1);
      end
      for (int i = 0; i < 9; i++) begin
         vectors++;
         if (i >= seq.size() || seq[i] != i % 8) begin
            miscompares++;
            $display("FAIL cont_slot_order[%0d]: got %0d expected %0d", i, (i < seq.size()) ? seq[i] : -1, i % 8);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      while (!(enc_a == 3'd3 && en_a) && n < 60) begin advance(); n++; end
      vectors++;
      if (n >= 60) begin miscompares++; $display("FAIL reset_mid_wait: got timeout expected slot 3"); end
      rst = 1;
      advance();
      rst = 0;
      vectors++;
      if (act_a !== 7'h00) begin miscompares++; $display("FAIL reset_mid: got %b expected %b", act_a, 7'h00); end
      advance();
      vectors++;
      if ({act_a, act_b} !== 14'h0) begin miscompares++; $display("FAIL reset_mid_idle: got %b/%b expected 0/0", act_a, act_b); end
   endtask

   task automatic test_single_masked();
      int slots[$];
      int pd_n = 0, t0, t_fall = -1;
      mask = 8'b1010_0100; single = 1; start = 1;
      advance();
      start = 0; t0 = cyc;
      for (int i = 0; i < 40; i++) begin
         vectors++;
         if ({act_a, act_b} !== {expw(0), expw(1)}) begin
            miscompares++;
            $display("FAIL single_cycle %0d: got %b/%b expected %b/%b", i, act_a, act_b, expw(0), expw(1));
         end
         if (ss_a) slots.push_back(int'(enc_a));
         if (pd_a) pd_n++;
         if (!busy_a && t_fall < 0) t_fall = cyc - t0;
         advance();
      end
      vectors++;
      if (slots.size() != 3 || slots[0] != 2 || slots[1] != 5 || slots[2] != 7) begin
         miscompares++;
         $display("FAIL single_slots: got %0d visits expected 2,5,7", slots.size());
      end
      vectors++;
      if (pd_n != 1) begin miscompares++; $display("FAIL single_pass_done: got %0d expected 1", pd_n); end
      vectors++;
      if (t_fall != 18) begin miscompares++; $display("FAIL single_busy_fall: got %0d expected 18", t_fall); end
      single = 0;
   endtask

   task automatic test_mask_zero();
      mask = 8'h00; start = 1;
      for (int i = 0; i < 20; i++) begin
         if (i == 3) start = 0;
         advance();
         vectors++;
         if ({busy_a, en_a, busy_b, en_b} !== 4'b0) begin
            miscompares++;
            $display("FAIL mask_zero %0d: got busy/en %b%b %b%b expected 00 00", i, busy_a, en_a, busy_b, en_b);
         end
      end
      start = 0;
   endtask

   task automatic test_stop_priority();
      int n = 0;
      mask = 8'hFF; single = 0; start = 1;
      advance();
      start = 0;
      while (!(enc_a == 3'd4 && en_a) && n < 60) begin advance(); n++; end
      vectors++;
      if (n >= 60) begin miscompares++; $display("FAIL stop_wait: got timeout expected slot 4"); end
      start = 1; stop = 1;
      advance();
      start = 0; stop = 0;
      vectors++;
      if (act_a !== 7'h00) begin miscompares++; $display("FAIL stop_priority: got %b expected %b", act_a, 7'h00); end
      vectors++;
      if ({act_a, act_b} !== {expw(0), expw(1)}) begin
         miscompares++;
         $display("FAIL stop_model: got %b/%b expected %b/%b", act_a, act_b, expw(0), expw(1));
      end
   endtask

   task automatic test_zero_blank();
      logic [2:0] want;
      mask = 8'h81; single = 0; start = 1;
      advance();
      start = 0;
      for (int i = 0; i < 40; i++) begin
         want = ((i / 4) % 2 == 1) ? 3'd7 : 3'd0;
         vectors++;
         if (en_b !== 1'b1 || enc_b !== want || pd_b !== (i > 0 && i % 8 == 0)) begin
            miscompares++;
            $display("FAIL zero_blank %0d: got en=%b enc=%0d pd=%b expected en=1 enc=%0d pd=%b",
                     i, en_b, enc_b, pd_b, want, (i > 0 && i % 8 == 0));
         end
         vectors++;
         if ({act_a, act_b} !== {expw(0), expw(1)}) begin
            miscompares++;
            $display("FAIL zero_blank_model %0d: got %b/%b expected %b/%b", i, act_a, act_b, expw(0), expw(1));
         end
         advance();
      end
      stop = 1;
      advance();
      stop = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         rst   = ($urandom_range(0, 199) == 0);
         stop  = ($urandom_range(0, 59) == 0);
         start = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 19) == 0) single = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 29) == 0) mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         advance();
         vectors++;
         if ({act_a, act_b} !== {expw(0), expw(1)}) begin
            miscompares++;
            $display("FAIL random_cycle %0d: got %b/%b expected %b/%b", i, act_a, act_b, expw(0), expw(1));
         end
      end
      rst = 0; stop = 0; start = 0;
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_reset_mid();
      test_single_masked();
      test_mask_zero();
      test_stop_priority();
      test_zero_blank();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
